// File: rtl/rggen_rtl_pkg.sv
// rtl/rggen_rtl_pkg.sv - shared access/status types and strobe helper for the register interface
package rggen_rtl_pkg;

  localparam int RGGEN_MAX_BUS_WIDTH    = 512;
  localparam int RGGEN_MAX_STROBE_WIDTH = RGGEN_MAX_BUS_WIDTH / 8;

  typedef enum logic [1:0] {
    RGGEN_READ  = 2'b10,
    RGGEN_WRITE = 2'b11
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    HOST_IDLE,
    HOST_BUSY,
    HOST_RESPONSE
  } rggen_host_state;

  // Callers size-cast in and out, so one function covers every bus width.
  function automatic logic [RGGEN_MAX_BUS_WIDTH-1:0] rggen_expand_strobe(
    input logic [RGGEN_MAX_STROBE_WIDTH-1:0] strobe
  );
    logic [RGGEN_MAX_BUS_WIDTH-1:0] mask;
    mask = '0;
    for (int i = 0; i < RGGEN_MAX_STROBE_WIDTH; i++) begin
      mask[8*i+:8] = {8{strobe[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/rggen_or_reducer.sv
// rtl/rggen_or_reducer.sv - bitwise OR of N packed WIDTH-bit lanes
module rggen_or_reducer #(
  parameter int WIDTH = 1,
  parameter int N     = 1
) (
  input  logic [WIDTH*N-1:0] i_data,
  output logic [WIDTH-1:0]   o_result
);

  always_comb begin
    o_result = '0;
    for (int i = 0; i < N; i++) begin
      o_result |= i_data[i*WIDTH+:WIDTH];
    end
  end

endmodule

// File: rtl/rggen_host_adapter.sv
// rtl/rggen_host_adapter.sv - valid/ready host bus to single-beat register access initiator
module rggen_host_adapter
  import rggen_rtl_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH       = 16,
  parameter int                       LOCAL_ADDRESS_WIDTH = 8,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS        = '0,
  parameter int                       BYTE_SIZE           = 256,
  parameter int                       BUS_WIDTH           = 32,
  parameter int                       REGISTERS           = 1,
  parameter bit                       ERROR_STATUS        = 1'b0,
  parameter logic [BUS_WIDTH-1:0]     DEFAULT_READ_DATA   = '0,
  parameter int                       TIMEOUT             = 0
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_req_valid,
  output logic                           o_req_ready,
  input  logic                           i_req_write,
  input  logic [ADDRESS_WIDTH-1:0]       i_req_address,
  input  logic [BUS_WIDTH-1:0]           i_req_write_data,
  input  logic [BUS_WIDTH/8-1:0]         i_req_strobe,
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic [1:0]                     o_rsp_status,
  output logic [BUS_WIDTH-1:0]           o_rsp_read_data,
  output logic                           o_register_valid,
  output logic [1:0]                     o_register_access,
  output logic [LOCAL_ADDRESS_WIDTH-1:0] o_register_address,
  output logic [BUS_WIDTH-1:0]           o_register_write_data,
  output logic [BUS_WIDTH-1:0]           o_register_strobe,
  input  logic [REGISTERS-1:0]           i_register_active,
  input  logic [REGISTERS-1:0]           i_register_ready,
  input  logic [2*REGISTERS-1:0]         i_register_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

  localparam int ADDR_LSB      = $clog2(BUS_WIDTH / 8);
  localparam int EXT_WIDTH     = ADDRESS_WIDTH + 1;
  localparam int COUNTER_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  // Range check is done one bit wider so a block ending at the top of the map does not wrap.
  localparam logic [EXT_WIDTH-1:0]           RANGE_BEGIN     = EXT_WIDTH'(BASE_ADDRESS);
  localparam logic [EXT_WIDTH-1:0]           RANGE_END       = RANGE_BEGIN + EXT_WIDTH'(BYTE_SIZE);
  localparam logic [LOCAL_ADDRESS_WIDTH-1:0] LOCAL_MASK      = ~LOCAL_ADDRESS_WIDTH'((1 << ADDR_LSB) - 1);
  localparam logic [COUNTER_WIDTH-1:0]       TIMEOUT_LAST    = COUNTER_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [1:0]                     UNMAPPED_STATUS = ERROR_STATUS ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;

  rggen_host_state state;
  rggen_host_state next_state;

  logic                           req_ready;
  logic                           in_range;
  logic                           write;
  logic [LOCAL_ADDRESS_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0]           write_data;
  logic [BUS_WIDTH-1:0]           strobe;
  logic [1:0]                     rsp_status;
  logic [BUS_WIDTH-1:0]           rsp_read_data;
  logic [COUNTER_WIDTH-1:0]       counter;

  logic                           accept;
  logic                           req_in_range;
  logic [LOCAL_ADDRESS_WIDTH-1:0] req_local_address;
  logic [BUS_WIDTH-1:0]           req_strobe_mask;
  logic                           any_active;
  logic                           active_ready;
  logic                           timeout_hit;
  logic                           complete;
  logic [1:0]                     complete_status;
  logic [BUS_WIDTH-1:0]           complete_data;

  logic [2*REGISTERS-1:0]         masked_status;
  logic [BUS_WIDTH*REGISTERS-1:0] masked_data;
  logic [1:0]                     collected_status;
  logic [BUS_WIDTH-1:0]           collected_data;

  assign accept            = i_req_valid && req_ready;
  assign req_in_range      = ({1'b0, i_req_address} >= RANGE_BEGIN) && ({1'b0, i_req_address} < RANGE_END);
  assign req_local_address = LOCAL_ADDRESS_WIDTH'(i_req_address - BASE_ADDRESS) & LOCAL_MASK;
  assign req_strobe_mask   = BUS_WIDTH'(rggen_expand_strobe(RGGEN_MAX_STROBE_WIDTH'(i_req_strobe)));

  // Only registers claiming the address contribute to the collected response.
  always_comb begin
    masked_status = '0;
    masked_data   = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      masked_status[2*i+:2]                = i_register_status[2*i+:2] & {2{i_register_active[i]}};
      masked_data[BUS_WIDTH*i+:BUS_WIDTH] = i_register_read_data[BUS_WIDTH*i+:BUS_WIDTH] & {BUS_WIDTH{i_register_active[i]}};
    end
  end

  rggen_or_reducer #(.WIDTH(2), .N(REGISTERS)) u_status_reducer (
    .i_data   (masked_status),
    .o_result (collected_status)
  );

  rggen_or_reducer #(.WIDTH(BUS_WIDTH), .N(REGISTERS)) u_data_reducer (
    .i_data   (masked_data),
    .o_result (collected_data)
  );

  assign any_active   = |i_register_active;
  assign active_ready = |(i_register_active & i_register_ready);
  assign timeout_hit  = (TIMEOUT > 0) && (counter == TIMEOUT_LAST);

  always_comb begin
    next_state       = state;
    complete         = 1'b0;
    o_req_ready      = req_ready;
    o_rsp_valid      = 1'b0;
    o_register_valid = 1'b0;
    case (state)
      HOST_IDLE: begin
        if (accept) next_state = HOST_BUSY;
      end
      HOST_BUSY: begin
        o_register_valid = in_range;
        complete         = !in_range || !any_active || active_ready || timeout_hit;
        if (complete) next_state = HOST_RESPONSE;
      end
      HOST_RESPONSE: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) next_state = HOST_IDLE;
      end
      default: next_state = HOST_IDLE;
    endcase
  end

  // A ready register wins over a timeout landing in the same cycle.
  always_comb begin
    complete_status = RGGEN_SLAVE_ERROR;
    complete_data   = '0;
    if (!in_range || !any_active) begin
      complete_status = UNMAPPED_STATUS;
      complete_data   = write ? '0 : DEFAULT_READ_DATA;
    end else if (active_ready) begin
      complete_status = collected_status;
      complete_data   = write ? '0 : collected_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= HOST_IDLE;
      req_ready <= 1'b0;
    end else begin
      state     <= next_state;
      req_ready <= (next_state == HOST_IDLE);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      in_range      <= 1'b0;
      write         <= 1'b0;
      address       <= '0;
      write_data    <= '0;
      strobe        <= '0;
      rsp_status    <= RGGEN_OKAY;
      rsp_read_data <= '0;
      counter       <= '0;
    end else begin
      if (accept) begin
        in_range   <= req_in_range;
        write      <= i_req_write;
        address    <= req_local_address;
        write_data <= i_req_write ? i_req_write_data : '0;
        strobe     <= i_req_write ? req_strobe_mask : '1;
        counter    <= '0;
      end else if ((state == HOST_BUSY) && in_range) begin
        counter <= counter + COUNTER_WIDTH'(1);
      end
      if (complete) begin
        rsp_status    <= complete_status;
        rsp_read_data <= complete_data;
      end
    end
  end

  assign o_rsp_status          = rsp_status;
  assign o_rsp_read_data       = rsp_read_data;
  assign o_register_access     = write ? RGGEN_WRITE : RGGEN_READ;
  assign o_register_address    = address;
  assign o_register_write_data = write_data;
  assign o_register_strobe     = strobe;

endmodule

// File: tb/tb_rggen_host_adapter.sv
// tb/tb_rggen_host_adapter.sv - randomized self-checking bench for rggen_host_adapter
module tb_rggen_host_adapter;

  localparam logic [15:0] BASE    = 16'h1000;
  localparam logic [31:0] DEFAULT = 32'hDEAD_BEEF;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_write = 1'b0;
  logic [15:0] i_req_address = '0;
  logic [31:0] i_req_write_data = '0;
  logic [3:0]  i_req_strobe = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [1:0]  o_rsp_status;
  logic [31:0] o_rsp_read_data;
  logic        o_register_valid;
  logic [1:0]  o_register_access;
  logic [7:0]  o_register_address;
  logic [31:0] o_register_write_data;
  logic [31:0] o_register_strobe;
  logic [3:0]  i_register_active;
  logic [3:0]  i_register_ready;
  logic [7:0]  i_register_status;
  logic [127:0] i_register_read_data;

  int n_checks = 0;
  int n_errors = 0;

  // Register block: register r sits at local offset 4*r; register 3 always reports EXOKAY.
  logic [31:0] reg_mem [4]   = '{32'h0BAD_0000, 32'h5555_5500, 32'h1234_5678, 32'hC0DE_0003};
  logic [31:0] model_mem [4] = '{32'h0BAD_0000, 32'h5555_5500, 32'h1234_5678, 32'hC0DE_0003};
  int busy_cnt = 0;
  int wait_cycles = 0;
  bit fault_mode = 1'b0;

  always #5 i_clk = ~i_clk;

  rggen_host_adapter #(
    .ADDRESS_WIDTH       (16),
    .LOCAL_ADDRESS_WIDTH (8),
    .BASE_ADDRESS        (BASE),
    .BYTE_SIZE           (256),
    .BUS_WIDTH           (32),
    .REGISTERS           (4),
    .ERROR_STATUS        (1'b1),
    .DEFAULT_READ_DATA   (DEFAULT),
    .TIMEOUT             (4)
  ) dut (
    .i_clk                 (i_clk),
    .i_rst_n               (i_rst_n),
    .i_req_valid           (i_req_valid),
    .o_req_ready           (o_req_ready),
    .i_req_write           (i_req_write),
    .i_req_address         (i_req_address),
    .i_req_write_data      (i_req_write_data),
    .i_req_strobe          (i_req_strobe),
    .o_rsp_valid           (o_rsp_valid),
    .i_rsp_ready           (i_rsp_ready),
    .o_rsp_status          (o_rsp_status),
    .o_rsp_read_data       (o_rsp_read_data),
    .o_register_valid      (o_register_valid),
    .o_register_access     (o_register_access),
    .o_register_address    (o_register_address),
    .o_register_write_data (o_register_write_data),
    .o_register_strobe     (o_register_strobe),
    .i_register_active     (i_register_active),
    .i_register_ready      (i_register_ready),
    .i_register_status     (i_register_status),
    .i_register_read_data  (i_register_read_data)
  );

  // Inactive registers still drive data and status so the adapter's masking is exercised.
  always_comb begin
    i_register_active = '0;
    for (int i = 0; i < 4; i++) begin
      i_register_active[i] = (o_register_address == 8'(i * 4));
    end
    if (fault_mode && o_register_address == 8'h04) i_register_active[0] = 1'b1;
    i_register_ready     = (busy_cnt >= wait_cycles) ? 4'hF : 4'h0;
    i_register_status    = 8'b01_00_00_00;
    i_register_read_data = {reg_mem[3], reg_mem[2], reg_mem[1], reg_mem[0]};
  end

  always @(posedge i_clk) begin
    busy_cnt <= o_register_valid ? busy_cnt + 1 : 0;
    if (o_register_valid && o_register_access == 2'b11 && busy_cnt >= wait_cycles) begin
      for (int i = 0; i < 4; i++) begin
        if (i_register_active[i])
          reg_mem[i] <= (reg_mem[i] & ~o_register_strobe) | (o_register_write_data & o_register_strobe);
      end
    end
  end

  task automatic check_value(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_req_ready();
    int guard = 0;
    while (!o_req_ready && guard < 10) begin
      @(negedge i_clk);
      guard++;
    end
    check_value("req_ready_idle", o_req_ready, 1);
  endtask

  task automatic do_txn(input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input int wt, input int hold);
    logic [16:0] a17;
    logic [15:0] off;
    logic [7:0]  loc;
    bit          in_rng;
    logic [3:0]  act;
    logic [1:0]  exp_status;
    logic [31:0] exp_data, exp_mask, exp_wdata;
    int          exp_cycles, exp_vcnt, n, vcnt;

    a17    = {1'b0, addr};
    in_rng = (a17 >= 17'h01000) && (a17 < 17'h01100);
    off    = addr - BASE;
    loc    = off[7:0] & 8'hFC;
    act    = '0;
    if (in_rng && loc < 8'h10) act[loc[3:2]] = 1'b1;
    if (fault_mode && in_rng && loc == 8'h04) act[0] = 1'b1;
    exp_mask = 32'hFFFF_FFFF;
    if (wr) for (int b = 0; b < 4; b++) exp_mask[8*b+:8] = st[b] ? 8'hFF : 8'h00;
    exp_wdata = wr ? wd : 32'h0;

    if (!in_rng || act == 4'h0) begin
      exp_status = 2'd2;
      exp_data   = wr ? 32'h0 : DEFAULT;
      exp_cycles = 1;
      exp_vcnt   = in_rng ? 1 : 0;
    end else if (wt < 4) begin
      exp_cycles = wt + 1;
      exp_vcnt   = exp_cycles;
      exp_status = 2'd0;
      exp_data   = 32'h0;
      for (int r = 0; r < 4; r++) begin
        if (act[r]) begin
          exp_status |= (r == 3) ? 2'd1 : 2'd0;
          if (!wr) exp_data |= model_mem[r];
          if (wr) model_mem[r] = (model_mem[r] & ~exp_mask) | (wd & exp_mask);
        end
      end
    end else begin
      exp_cycles = 4;
      exp_vcnt   = 4;
      exp_status = 2'd2;
      exp_data   = 32'h0;
    end

    wait_cycles = wt;
    wait_req_ready();
    i_req_valid      = 1'b1;
    i_req_write      = wr;
    i_req_address    = addr;
    i_req_write_data = wd;
    i_req_strobe     = st;
    @(negedge i_clk);
    i_req_valid      = 1'b0;
    i_req_write_data = $urandom;
    check_value("req_ready_busy", o_req_ready, 0);
    if (in_rng) begin
      check_value("reg_address", o_register_address, loc);
      check_value("reg_strobe", o_register_strobe, exp_mask);
      check_value("reg_wdata", o_register_write_data, exp_wdata);
      check_value("reg_access", o_register_access, wr ? 2'b11 : 2'b10);
    end
    n = 0;
    vcnt = 0;
    while (!o_rsp_valid && n < 20) begin
      if (o_register_valid) vcnt++;
      n++;
      @(negedge i_clk);
    end
    check_value("latency", n, exp_cycles);
    check_value("reg_valid_cycles", vcnt, exp_vcnt);
    check_value("rsp_status", o_rsp_status, exp_status);
    check_value("rsp_data", o_rsp_read_data, exp_data);
    check_value("reg_valid_after", o_register_valid, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge i_clk);
      check_value("hold_valid", o_rsp_valid, 1);
      check_value("hold_status", o_rsp_status, exp_status);
      check_value("hold_data", o_rsp_read_data, exp_data);
      check_value("hold_req_ready", o_req_ready, 0);
    end
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    check_value("rsp_valid_done", o_rsp_valid, 0);
    check_value("req_ready_done", o_req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    check_value("rst_req_ready", o_req_ready, 0);
    check_value("rst_rsp_valid", o_rsp_valid, 0);
    check_value("rst_reg_valid", o_register_valid, 0);
    check_value("rst_status", o_rsp_status, 0);
    check_value("rst_data", o_rsp_read_data, 0);
    check_value("rst_strobe", o_register_strobe, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    do_txn(1'b1, BASE + 16'h04, 32'h0000_00AA, 4'b0001, 0, 0);
    do_txn(1'b0, BASE + 16'h08, 32'h0, 4'hF, 3, 0);
    do_txn(1'b0, BASE + 16'h100, 32'h0, 4'hF, 0, 0);
    do_txn(1'b0, BASE + 16'h0C, 32'h0, 4'hF, 4, 0);
    do_txn(1'b0, BASE + 16'h04, 32'h0, 4'hF, 1, 5);
    do_txn(1'b0, 16'h0FFF, 32'h0, 4'hF, 0, 1);
    do_txn(1'b0, 16'h10FF, 32'h0, 4'hF, 0, 0);
    do_txn(1'b1, BASE + 16'h0B, 32'hA5A5_1234, 4'b1010, 2, 0);
    do_txn(1'b0, BASE + 16'h0B, 32'h0, 4'h0, 0, 0);
    do_txn(1'b0, BASE + 16'h0F, 32'h0, 4'h0, 3, 0);
    fault_mode = 1'b1;
    do_txn(1'b0, BASE + 16'h04, 32'h0, 4'hF, 0, 0);
    fault_mode = 1'b0;

    wait_cycles = 99;
    wait_req_ready();
    i_req_valid   = 1'b1;
    i_req_write   = 1'b1;
    i_req_address = BASE + 16'h08;
    i_req_strobe  = 4'hF;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    @(negedge i_clk);
    check_value("mid_reg_valid", o_register_valid, 1);
    #2 i_rst_n = 1'b0;
    #1;
    check_value("arst_reg_valid", o_register_valid, 0);
    check_value("arst_req_ready", o_req_ready, 0);
    check_value("arst_rsp_valid", o_rsp_valid, 0);
    check_value("arst_address", o_register_address, 0);
    check_value("arst_strobe", o_register_strobe, 0);
    check_value("arst_status", o_rsp_status, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    do_txn(1'b0, BASE + 16'h08, 32'h0, 4'hF, 0, 0);

    for (int t = 0; t < 40; t++) begin
      do_txn(1'($urandom_range(0, 1)), 16'(32'h0FE0 + $urandom_range(0, 319)), $urandom,
             4'($urandom_range(0, 15)), $urandom_range(0, 5), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
